// File: rtl/matrix_multiply_stream.sv
// matrix_multiply_stream
// Streaming fixed-point row multiplier: holds an N x N operand B and turns
// each accepted row of A into the matching row of C = A*B, one MAC step per
// cycle, followed by a one-cycle write strobe towards the matrix store.
module matrix_multiply_stream #(
  parameter int N    = 32,
  parameter int W    = 32,
  parameter int FRAC = 0,
  parameter int SAT  = 1,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            b_wr,
  input  logic [IDXW-1:0] b_index,
  input  logic [N*W-1:0]  b_row,
  output logic            b_ready,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*W-1:0]  a_row,
  input  logic [IDXW-1:0] a_index,
  input  logic            select_line_in,
  output logic [N*W-1:0]  out,
  output logic [IDXW-1:0] out_address,
  output logic            select_line_out,
  output logic            write_data,
  output logic            busy,
  output logic            err
);

  // Accumulator is wide enough that N full-scale products can never overflow.
  localparam int AW = 2*W + IDXW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [IDXW:0]         N_LIM  = (IDXW+1)'(N);
  localparam logic [IDXW-1:0]       K_LAST = IDXW'(N-1);
  localparam logic signed [AW-1:0]  MAX_V  = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0]  MIN_V  = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic [1:0]             state;
  logic [IDXW-1:0]        k;
  logic signed [W-1:0]    a_buf [N];
  logic signed [W-1:0]    b_buf [N][N];
  logic signed [AW-1:0]   acc [N];
  logic [IDXW-1:0]        row_addr;
  logic                   row_sel;

  logic                   idx_ok;
  logic                   b_accept;
  logic                   b_reject;
  logic                   a_accept;
  logic                   mac_last;
  logic signed [2*W-1:0]  prod [N];
  logic signed [AW-1:0]   acc_next [N];
  logic signed [AW-1:0]   shifted [N];
  logic [N*W-1:0]         result;

  // B is frozen during MAC; a B write request always wins over an A row.
  assign b_ready  = (state != MAC);
  assign a_ready  = ((state == IDLE) || (state == OUT)) && !b_wr;
  assign idx_ok   = ({1'b0, b_index} < N_LIM);
  assign b_accept = b_wr && b_ready && idx_ok;
  assign b_reject = b_wr && !(b_ready && idx_ok);
  assign a_accept = a_valid && a_ready;
  assign mac_last = (state == MAC) && (k == K_LAST);
  assign busy     = (state == MAC);

  // One MAC step for all columns, plus the scaled/limited view of the sums.
  always_comb begin
    result = '0;
    for (int j = 0; j < N; j++) begin
      prod[j]     = a_buf[k] * b_buf[k][j];
      acc_next[j] = acc[j] + {{(AW-2*W){prod[j][2*W-1]}}, prod[j]};
      shifted[j]  = acc_next[j] >>> FRAC;
      if (SAT != 0) begin
        if (shifted[j] > MAX_V)
          result[j*W +: W] = MAX_V[W-1:0];
        else if (shifted[j] < MIN_V)
          result[j*W +: W] = MIN_V[W-1:0];
        else
          result[j*W +: W] = shifted[j][W-1:0];
      end else begin
        result[j*W +: W] = shifted[j][W-1:0];
      end
    end
  end

  // Sequencer and datapath: capture an A row, then walk k across N steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      row_addr <= '0;
      row_sel  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        a_buf[i] <= '0;
        acc[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE:    if (a_accept) state <= MAC;
        MAC:     if (k == K_LAST) state <= OUT;
        OUT:     state <= a_accept ? MAC : IDLE;
        default: state <= IDLE;
      endcase
      if (a_accept) begin
        row_addr <= a_index;
        row_sel  <= select_line_in;
        k        <= '0;
        for (int i = 0; i < N; i++) begin
          a_buf[i] <= a_row[i*W +: W];
          acc[i]   <= '0;
        end
      end else if (state == MAC) begin
        k <= mac_last ? '0 : k + 1'b1;
        for (int i = 0; i < N; i++) acc[i] <= acc_next[i];
      end
    end
  end

  // B operand buffer, written one row at a time outside MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          b_buf[i][j] <= '0;
    end else if (b_accept) begin
      for (int j = 0; j < N; j++) b_buf[b_index][j] <= b_row[j*W +: W];
    end
  end

  // Result registers load as the last MAC step completes; strobe for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out             <= '0;
      out_address     <= '0;
      select_line_out <= 1'b0;
      write_data      <= 1'b0;
    end else begin
      write_data <= mac_last;
      if (mac_last) begin
        out             <= result;
        out_address     <= row_addr;
        select_line_out <= row_sel;
      end
    end
  end

  // Sticky error on any dropped B write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err <= 1'b0;
    else if (b_reject) err <= 1'b1;
  end

endmodule

// File: tb/tb_matrix_multiply_stream.sv
// tb_matrix_multiply_stream
// Three small N=4/W=16 instances (FRAC=8 saturating, FRAC=0 saturating,
// FRAC=0 wrapping) share one stimulus; a default N=32/W=32 instance runs the
// streaming scenario. Expected rows are queued when an A row is accepted.
module tb_matrix_multiply_stream;

  localparam int SN = 4;
  localparam int SW = 16;
  localparam int SI = 3;
  localparam int DN = 32;
  localparam int DW = 32;
  localparam int DI = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              s_b_wr, s_a_valid, s_sel;
  logic [SI-1:0]     s_b_index, s_a_index;
  logic [SN*SW-1:0]  s_b_row, s_a_row;
  logic              f_b_ready, f_a_ready, f_sel_out, f_write_data, f_busy, f_err;
  logic              p_b_ready, p_a_ready, p_sel_out, p_write_data, p_busy, p_err;
  logic              w_b_ready, w_a_ready, w_sel_out, w_write_data, w_busy, w_err;
  logic [SN*SW-1:0]  f_out, p_out, w_out;
  logic [SI-1:0]     f_addr, p_addr, w_addr;

  logic              d_b_wr, d_a_valid, d_sel;
  logic [DI-1:0]     d_b_index, d_a_index;
  logic [DN*DW-1:0]  d_b_row, d_a_row;
  logic              d_b_ready, d_a_ready, d_sel_out, d_write_data, d_busy, d_err;
  logic [DN*DW-1:0]  d_out;
  logic [DI-1:0]     d_addr;

  matrix_multiply_stream #(.N(SN), .W(SW), .FRAC(8), .SAT(1), .IDXW(SI)) dut_f (
    .clk(clk), .reset(reset), .b_wr(s_b_wr), .b_index(s_b_index), .b_row(s_b_row),
    .b_ready(f_b_ready), .a_valid(s_a_valid), .a_ready(f_a_ready), .a_row(s_a_row),
    .a_index(s_a_index), .select_line_in(s_sel), .out(f_out), .out_address(f_addr),
    .select_line_out(f_sel_out), .write_data(f_write_data), .busy(f_busy), .err(f_err));

  matrix_multiply_stream #(.N(SN), .W(SW), .FRAC(0), .SAT(1), .IDXW(SI)) dut_p (
    .clk(clk), .reset(reset), .b_wr(s_b_wr), .b_index(s_b_index), .b_row(s_b_row),
    .b_ready(p_b_ready), .a_valid(s_a_valid), .a_ready(p_a_ready), .a_row(s_a_row),
    .a_index(s_a_index), .select_line_in(s_sel), .out(p_out), .out_address(p_addr),
    .select_line_out(p_sel_out), .write_data(p_write_data), .busy(p_busy), .err(p_err));

  matrix_multiply_stream #(.N(SN), .W(SW), .FRAC(0), .SAT(0), .IDXW(SI)) dut_w (
    .clk(clk), .reset(reset), .b_wr(s_b_wr), .b_index(s_b_index), .b_row(s_b_row),
    .b_ready(w_b_ready), .a_valid(s_a_valid), .a_ready(w_a_ready), .a_row(s_a_row),
    .a_index(s_a_index), .select_line_in(s_sel), .out(w_out), .out_address(w_addr),
    .select_line_out(w_sel_out), .write_data(w_write_data), .busy(w_busy), .err(w_err));

  matrix_multiply_stream dut_d (
    .clk(clk), .reset(reset), .b_wr(d_b_wr), .b_index(d_b_index), .b_row(d_b_row),
    .b_ready(d_b_ready), .a_valid(d_a_valid), .a_ready(d_a_ready), .a_row(d_a_row),
    .a_index(d_a_index), .select_line_in(d_sel), .out(d_out), .out_address(d_addr),
    .select_line_out(d_sel_out), .write_data(d_write_data), .busy(d_busy), .err(d_err));

  typedef struct {
    logic [1023:0] data;
    logic [4:0]    addr;
    logic          sel;
  } exp_t;

  exp_t q_f[$], q_p[$], q_w[$], q_d[$];
  exp_t fe, pe, we, de;
  int   d_strobes[$];
  int   d_bad;

  logic signed [31:0] sb [SN][SN];
  logic signed [31:0] db [DN][DN];
  logic signed [31:0] gm [DN][DN];
  logic signed [31:0] s_arow [SN];
  logic signed [31:0] d_arow [DN];

  // Reference element: exact sum, floor shift, then clamp or wrap.
  function automatic logic [31:0] model_elem(input int n, input int w, input int frac,
                                             input bit sat, input bit use_d, input int j);
    logic signed [127:0] acc, x, y, r, maxv, minv;
    acc = '0;
    for (int kk = 0; kk < n; kk++) begin
      if (use_d) begin x = d_arow[kk]; y = db[kk][j]; end
      else       begin x = s_arow[kk]; y = sb[kk][j]; end
      acc = acc + x * y;
    end
    r    = acc >>> frac;
    maxv = (128'sd1 <<< (w-1)) - 128'sd1;
    minv = -(128'sd1 <<< (w-1));
    if (sat && r > maxv) r = maxv;
    else if (sat && r < minv) r = minv;
    return r[31:0];
  endfunction

  task automatic push_small(input logic [2:0] idx, input logic sel);
    exp_t e;
    logic [31:0] v;
    e.addr = {2'b00, idx};
    e.sel  = sel;
    e.data = '0;
    for (int j = 0; j < SN; j++) begin v = model_elem(SN, SW, 8, 1, 0, j); e.data[j*16 +: 16] = v[15:0]; end
    q_f.push_back(e);
    e.data = '0;
    for (int j = 0; j < SN; j++) begin v = model_elem(SN, SW, 0, 1, 0, j); e.data[j*16 +: 16] = v[15:0]; end
    q_p.push_back(e);
    e.data = '0;
    for (int j = 0; j < SN; j++) begin v = model_elem(SN, SW, 0, 0, 0, j); e.data[j*16 +: 16] = v[15:0]; end
    q_w.push_back(e);
  endtask

  task automatic push_default(input logic [4:0] idx, input logic sel);
    exp_t e;
    e.addr = idx;
    e.sel  = sel;
    e.data = '0;
    for (int j = 0; j < DN; j++) e.data[j*32 +: 32] = model_elem(DN, DW, 0, 1, 1, j);
    q_d.push_back(e);
  endtask

  // Scoreboard monitors: every strobe must match the oldest pending row.
  always @(negedge clk) begin
    if (f_write_data === 1'b1) begin
      checks++;
      if (q_f.size() == 0) begin
        errors++; $display("[TB] FAIL f_strobe: unexpected write_data at addr=%0d, expected none", f_addr);
      end else begin
        fe = q_f.pop_front();
        if (f_out !== fe.data[63:0] || f_addr !== fe.addr[2:0] || f_sel_out !== fe.sel) begin
          errors++;
          $display("[TB] FAIL f_row: got out=%h addr=%0d sel=%0d, expected out=%h addr=%0d sel=%0d",
                   f_out, f_addr, f_sel_out, fe.data[63:0], fe.addr[2:0], fe.sel);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (p_write_data === 1'b1) begin
      checks++;
      if (q_p.size() == 0) begin
        errors++; $display("[TB] FAIL p_strobe: unexpected write_data at addr=%0d, expected none", p_addr);
      end else begin
        pe = q_p.pop_front();
        if (p_out !== pe.data[63:0] || p_addr !== pe.addr[2:0] || p_sel_out !== pe.sel) begin
          errors++;
          $display("[TB] FAIL p_row: got out=%h addr=%0d sel=%0d, expected out=%h addr=%0d sel=%0d",
                   p_out, p_addr, p_sel_out, pe.data[63:0], pe.addr[2:0], pe.sel);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (w_write_data === 1'b1) begin
      checks++;
      if (q_w.size() == 0) begin
        errors++; $display("[TB] FAIL w_strobe: unexpected write_data at addr=%0d, expected none", w_addr);
      end else begin
        we = q_w.pop_front();
        if (w_out !== we.data[63:0] || w_addr !== we.addr[2:0] || w_sel_out !== we.sel) begin
          errors++;
          $display("[TB] FAIL w_row: got out=%h addr=%0d sel=%0d, expected out=%h addr=%0d sel=%0d",
                   w_out, w_addr, w_sel_out, we.data[63:0], we.addr[2:0], we.sel);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (d_write_data === 1'b1) begin
      d_strobes.push_back(cyc);
      checks++;
      if (q_d.size() == 0) begin
        errors++; $display("[TB] FAIL d_strobe: unexpected write_data at addr=%0d, expected none", d_addr);
      end else begin
        de = q_d.pop_front();
        d_bad = -1;
        for (int j = 0; j < DN; j++)
          if (d_bad < 0 && d_out[j*32 +: 32] !== de.data[j*32 +: 32]) d_bad = j;
        if (d_bad >= 0 || d_addr !== de.addr || d_sel_out !== de.sel) begin
          errors++;
          if (d_bad < 0) d_bad = 0;
          $display("[TB] FAIL d_row: got elem[%0d]=%h addr=%0d sel=%0d, expected elem=%h addr=%0d sel=%0d",
                   d_bad, d_out[d_bad*32 +: 32], d_addr, d_sel_out, de.data[d_bad*32 +: 32], de.addr, de.sel);
        end
      end
    end
  end

  task automatic clear_models();
    for (int i = 0; i < SN; i++) for (int j = 0; j < SN; j++) sb[i][j] = '0;
    for (int i = 0; i < DN; i++) for (int j = 0; j < DN; j++) db[i][j] = '0;
    q_f.delete(); q_p.delete(); q_w.delete(); q_d.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_b_wr = 1'b0; s_a_valid = 1'b0; d_b_wr = 1'b0; d_a_valid = 1'b0;
    clear_models();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_b_small(input int idx, input logic [63:0] row);
    @(negedge clk);
    s_b_wr = 1'b1; s_b_index = 3'(idx); s_b_row = row;
    @(posedge clk);
    if (idx < SN)
      for (int j = 0; j < SN; j++) sb[idx][j] = {{16{row[j*16+15]}}, row[j*16 +: 16]};
    @(negedge clk);
    s_b_wr = 1'b0;
  endtask

  task automatic write_identity_small();
    for (int i = 0; i < SN; i++) write_b_small(i, 64'h0100 << (16*i));
  endtask

  task automatic set_a_small(input int idx, input logic [63:0] row, input logic sel);
    s_a_index = 3'(idx); s_a_row = row; s_sel = sel;
    for (int j = 0; j < SN; j++) s_arow[j] = {{16{row[j*16+15]}}, row[j*16 +: 16]};
  endtask

  // Offers one A row and returns at the falling edge after it is taken.
  task automatic send_small(input int idx, input logic [63:0] row, input logic sel);
    bit ok, rdy;
    @(negedge clk);
    set_a_small(idx, row, sel);
    s_a_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      #1 rdy = f_a_ready;
      @(posedge clk);
      if (rdy) ok = 1; else @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL a_accept_small: got a_ready=0 for 100 cycles, expected 1"); end
    else push_small(3'(idx), sel);
    @(negedge clk);
    s_a_valid = 1'b0;
  endtask

  task automatic wait_strobe_small();
    bit seen;
    seen = 0;
    for (int t = 0; t < 60 && !seen; t++) begin
      @(negedge clk);
      if (f_write_data === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL strobe_timeout: got no write_data in 60 cycles, expected 1"); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (f_out !== '0) begin errors++; $display("[TB] FAIL rst_f_out: got %h expected 0", f_out); end
    checks++; if (d_out !== '0) begin errors++; $display("[TB] FAIL rst_d_out: got nonzero expected 0"); end
    checks++; if ({f_write_data, f_busy, f_err, f_addr, f_sel_out} !== '0) begin
      errors++; $display("[TB] FAIL rst_f_flags: got wd=%b busy=%b err=%b addr=%0d sel=%b expected all 0",
                         f_write_data, f_busy, f_err, f_addr, f_sel_out); end
    checks++; if ({d_write_data, d_busy, d_err, d_addr, d_sel_out} !== '0) begin
      errors++; $display("[TB] FAIL rst_d_flags: got wd=%b busy=%b err=%b expected all 0", d_write_data, d_busy, d_err); end
    checks++; if (f_a_ready !== 1'b1 || f_b_ready !== 1'b1 || d_a_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_ready: got a_ready=%b b_ready=%b d_a_ready=%b expected 1", f_a_ready, f_b_ready, d_a_ready); end
  endtask

  task automatic test_identity();
    do_reset();
    write_identity_small();
    send_small(2, 64'h7FFF_0180_FF00_0010, 1'b1);
    repeat (3) @(negedge clk);
    checks++; if (f_write_data !== 1'b0) begin errors++; $display("[TB] FAIL id_early: got write_data=%b expected 0", f_write_data); end
    @(negedge clk);
    checks++; if (f_write_data !== 1'b1) begin errors++; $display("[TB] FAIL id_strobe: got write_data=%b expected 1", f_write_data); end
    checks++; if (f_out !== 64'h7FFF_0180_FF00_0010 || f_addr !== 3'd2) begin
      errors++; $display("[TB] FAIL id_out: got out=%h addr=%0d expected out=7fff0180ff000010 addr=2", f_out, f_addr); end
    @(negedge clk);
    checks++; if (f_write_data !== 1'b0) begin errors++; $display("[TB] FAIL id_late: got write_data=%b expected 0", f_write_data); end
    checks++; if (f_out !== 64'h7FFF_0180_FF00_0010) begin errors++; $display("[TB] FAIL id_hold: got out=%h expected 7fff0180ff000010", f_out); end
  endtask

  task automatic test_negative();
    do_reset();
    write_b_small(0, 64'h0000_0000_0000_0180);
    send_small(0, 64'h0000_0000_0000_FF80, 1'b0);
    wait_strobe_small();
    checks++; if (f_out[15:0] !== 16'hFF40 || f_out[63:16] !== 48'h0) begin
      errors++; $display("[TB] FAIL neg_frac: got out=%h expected 000000000000ff40", f_out); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < SN; i++) write_b_small(i, {4{16'h7FFF}});
    send_small(1, {4{16'h7FFF}}, 1'b0);
    wait_strobe_small();
    checks++; if (p_out !== {4{16'h7FFF}}) begin errors++; $display("[TB] FAIL sat_clamp: got %h expected 7fff7fff7fff7fff", p_out); end
    checks++; if (w_out !== {4{16'h0004}}) begin errors++; $display("[TB] FAIL sat_wrap: got %h expected 0004000400040004", w_out); end
  endtask

  task automatic test_handshake();
    do_reset();
    write_b_small(0, 64'h0000_0000_0000_0100);
    write_b_small(2, 64'h0000_0100_0000_0000);
    write_b_small(3, 64'h0100_0000_0000_0000);
    @(negedge clk);
    s_b_wr = 1'b1; s_b_index = 3'd1; s_b_row = 64'h0000_0000_0100_0000;
    set_a_small(3, 64'h0040_0030_0020_0010, 1'b1);
    s_a_valid = 1'b1;
    #1;
    checks++; if (f_a_ready !== 1'b0 || f_b_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL hs_priority: got a_ready=%b b_ready=%b expected 0 and 1", f_a_ready, f_b_ready); end
    @(posedge clk);
    sb[1][1] = 32'sh100;
    @(negedge clk);
    s_b_wr = 1'b0;
    #1;
    checks++; if (f_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL hs_next: got a_ready=%b expected 1", f_a_ready); end
    @(posedge clk);
    push_small(3'd3, 1'b1);
    @(negedge clk);
    s_a_valid = 1'b0;
    s_b_wr = 1'b1; s_b_index = 3'd0; s_b_row = {4{16'hAAAA}};
    #1;
    checks++; if (f_b_ready !== 1'b0 || f_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL hs_mac_block: got b_ready=%b busy=%b expected 0 and 1", f_b_ready, f_busy); end
    @(negedge clk);
    s_b_wr = 1'b0;
    checks++; if (f_err !== 1'b1) begin errors++; $display("[TB] FAIL hs_mac_err: got err=%b expected 1", f_err); end
    wait_strobe_small();
    do_reset();
    checks++; if (f_err !== 1'b0) begin errors++; $display("[TB] FAIL hs_err_clear: got err=%b expected 0", f_err); end
    write_b_small(5, {4{16'h1234}});
    checks++; if (f_err !== 1'b1) begin errors++; $display("[TB] FAIL hs_idx_err: got err=%b expected 1", f_err); end
    send_small(1, {4{16'h0100}}, 1'b0);
    wait_strobe_small();
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_identity_small();
    send_small(1, 64'h0040_0030_0020_0010, 1'b1);
    wait_strobe_small();
    send_small(2, 64'h0011_0022_0033_0044, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (f_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got busy=%b expected 1", f_busy); end
    reset = 1'b1;
    clear_models();
    #1;
    checks++; if (f_out !== '0 || f_addr !== '0 || f_sel_out !== 1'b0 || f_write_data !== 1'b0 || f_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_async: got out=%h addr=%0d sel=%b wd=%b busy=%b expected all 0",
                         f_out, f_addr, f_sel_out, f_write_data, f_busy); end
    #2;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_small(3, {4{16'h0100}}, 1'b0);
    wait_strobe_small();
    write_identity_small();
    send_small(0, 64'h0001_0002_0003_0004, 1'b1);
    wait_strobe_small();
  endtask

  task automatic test_back_to_back();
    bit ok, rdy;
    int n;
    for (int i = 0; i < DN; i++)
      for (int j = 0; j < DN; j++) begin
        gm[i][j] = 32'(((i*37 + j*11) % 65) - 32);
        if (i == j && i % 4 == 0) gm[i][j] = 32'sh4000_0000 + 32'(i);
        if (i == j && i % 4 == 2) gm[i][j] = -32'sh4000_0000 - 32'(i);
      end
    for (int i = 0; i < DN; i++) begin
      @(negedge clk);
      d_b_wr = 1'b1; d_b_index = 5'(i);
      for (int j = 0; j < DN; j++) d_b_row[j*32 +: 32] = gm[i][j];
      @(posedge clk);
      for (int j = 0; j < DN; j++) db[i][j] = gm[i][j];
    end
    @(negedge clk);
    d_b_wr = 1'b0;
    d_strobes.delete();
    d_a_valid = 1'b1;
    for (int r = 0; r < DN; r++) begin
      d_a_index = 5'(r); d_sel = r[0];
      for (int j = 0; j < DN; j++) begin d_a_row[j*32 +: 32] = gm[r][j]; d_arow[j] = gm[r][j]; end
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        #1 rdy = d_a_ready;
        @(posedge clk);
        if (rdy) ok = 1; else @(negedge clk);
      end
      checks++;
      if (!ok) begin errors++; $display("[TB] FAIL d_accept: got a_ready=0 for row %0d, expected 1", r); end
      else push_default(5'(r), r[0]);
      @(negedge clk);
    end
    d_a_valid = 1'b0;
    for (int t = 0; t < 100 && q_d.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    n = d_strobes.size();
    checks++; if (n !== DN) begin errors++; $display("[TB] FAIL d_count: got %0d strobes expected %0d", n, DN); end
    for (int i = 1; i < n; i++) begin
      checks++;
      if (d_strobes[i] - d_strobes[i-1] !== DN + 1) begin
        errors++; $display("[TB] FAIL d_spacing: got %0d cycles between strobes %0d and %0d, expected %0d",
                           d_strobes[i] - d_strobes[i-1], i-1, i, DN + 1); end
    end
  endtask

  initial begin
    s_b_wr = 1'b0; s_b_index = '0; s_b_row = '0; s_a_valid = 1'b0; s_a_row = '0; s_a_index = '0; s_sel = 1'b0;
    d_b_wr = 1'b0; d_b_index = '0; d_b_row = '0; d_a_valid = 1'b0; d_a_row = '0; d_a_index = '0; d_sel = 1'b0;
    for (int j = 0; j < SN; j++) s_arow[j] = '0;
    for (int j = 0; j < DN; j++) d_arow[j] = '0;
    test_reset();
    test_identity();
    test_negative();
    test_saturation();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (q_f.size() + q_p.size() + q_w.size() + q_d.size() != 0) begin
      errors++; $display("[TB] FAIL leftover: got %0d/%0d/%0d/%0d pending rows, expected 0",
                         q_f.size(), q_p.size(), q_w.size(), q_d.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500000 ns, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
